// File: rtl/btn_press_classifier_pkg.sv
// Shared button definitions: FSM state encodings and default tick constants
// used by the debouncer, the press classifier and the LED blocks.
// The double-click states exist only when BTN_DOUBLE_EN is defined.
package btn_press_classifier_pkg;

  // Defaults shared across the button blocks
  localparam int BTN_LONG_TICKS_DEF = 1000;
  localparam int BTN_GAP_TICKS_DEF  = 250;
  localparam int BTN_CNT_W_DEF      = 16;

  localparam logic [2:0] BTN_ST_IDLE      = 3'd0;
  localparam logic [2:0] BTN_ST_PRESSED   = 3'd1;
  localparam logic [2:0] BTN_ST_LONG_HELD = 3'd2;
  localparam logic [2:0] BTN_ST_WAIT_GAP  = 3'd3;
  localparam logic [2:0] BTN_ST_SECOND    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = BTN_ST_IDLE,
    ST_PRESSED   = BTN_ST_PRESSED,
`ifdef BTN_DOUBLE_EN
    ST_LONG_HELD = BTN_ST_LONG_HELD,
    ST_WAIT_GAP  = BTN_ST_WAIT_GAP,
    ST_SECOND    = BTN_ST_SECOND
`else
    ST_LONG_HELD = BTN_ST_LONG_HELD
`endif
  } btn_state_e;

endpackage

// File: rtl/btn_press_classifier_if.sv
// Button classifier bus: debounced level in, event pulses and status out.
// master = debouncer/controller side, slave = classifier.
interface btn_press_classifier_if;
  import btn_press_classifier_pkg::*;

  logic in_level;
  logic press_short;
  logic press_long;
  logic press_double;
  logic held;
  logic busy;

  modport master (
    output in_level,
    input  press_short, press_long, press_double, held, busy
  );

  modport slave (
    input  in_level,
    output press_short, press_long, press_double, held, busy
  );
endinterface

// File: rtl/btn_press_classifier.sv
// Button press classifier: turns a debounced level into short/long/double
// event pulses plus held/busy status. All outputs registered.
// Optional feature macro: BTN_DOUBLE_EN (double-click detection; delays
// press_short by the gap window).
module btn_press_classifier
  import btn_press_classifier_pkg::*;
#(
  parameter int LONG_TICKS = BTN_LONG_TICKS_DEF,
  parameter int GAP_TICKS  = BTN_GAP_TICKS_DEF,
  parameter int CNT_W      = BTN_CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  btn_press_classifier_if.slave bus
);

  // Reject configurations the counter cannot represent
  if (LONG_TICKS < 2) begin : g_bad_long
    $error("btn_press_classifier: LONG_TICKS must be >= 2");
  end
  if (GAP_TICKS < 2) begin : g_bad_gap
    $error("btn_press_classifier: GAP_TICKS must be >= 2");
  end
  if ((CNT_W < 31) && (((1 << CNT_W) <= LONG_TICKS) || ((1 << CNT_W) <= GAP_TICKS))) begin : g_bad_w
    $error("btn_press_classifier: CNT_W too small for tick counts");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_DOUBLE_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;
`ifdef BTN_DOUBLE_EN
  logic             double_q, double_d;
`endif

  // Next-state, pulse and counter decisions
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_DOUBLE_EN
    double_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_level) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        // Release is checked first so it wins on the long-threshold cycle
        if (!bus.in_level) begin
`ifdef BTN_DOUBLE_EN
          state_d = ST_WAIT_GAP;
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (!bus.in_level) state_d = ST_IDLE;
      end
`ifdef BTN_DOUBLE_EN
      ST_WAIT_GAP: begin
        // A re-press on the timeout cycle still counts as a second click
        if (bus.in_level) begin
          state_d = ST_SECOND;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SECOND: begin
        if (!bus.in_level) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    held_d = (state_d == ST_LONG_HELD);
    busy_d = (state_d != ST_IDLE);

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  // State, counter and registered outputs; reset aborts silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BTN_DOUBLE_EN
  // Double-click pulse register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) double_q <= 1'b0;
    else      double_q <= double_d;
  end
  assign bus.press_double = double_q;
`else
  assign bus.press_double = 1'b0;
`endif

  assign bus.press_short = short_q;
  assign bus.press_long  = long_q;
  assign bus.held        = held_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Self-checking bench for btn_press_classifier (LONG_TICKS=8, GAP_TICKS=4).
// Works with or without BTN_DOUBLE_EN; the reference model classifies the
// sample history of the current press sequence directly.
module tb_btn_press_classifier;
  localparam int LT = 8;
  localparam int GT = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_press_classifier_if bus ();

  btn_press_classifier #(.LONG_TICKS(LT), .GAP_TICKS(GT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: samples since the first high sample of the current sequence
  bit seq[$];
  bit m_short, m_long, m_double, m_held, m_busy;

  typedef struct packed {
    bit       in;
    bit [4:0] exp;   // {short, long, double, held, busy}
  } vec_t;
  vec_t tbl[14];

  function automatic int first_from(int from, bit val);
    for (int i = from; i < seq.size(); i++) if (seq[i] == val) return i;
    return -1;
  endfunction

  task automatic model_step(bit v);
    int n, k;
    m_short = 0; m_long = 0; m_double = 0;
    if (seq.size() == 0) begin
      if (v) seq.push_back(1'b1);
    end else begin
      seq.push_back(v);
      n = seq.size() - 1;
      k = first_from(1, 1'b0);
      if (k < 0) begin
        if (n == LT) m_long = 1;
      end else if (k > LT) begin
        seq.delete();              // end of a long press
      end else begin
`ifdef BTN_DOUBLE_EN
        int j;
        j = first_from(k, 1'b1);
        if (j < 0) begin
          if (n - k == GT) begin m_short = 1; seq.delete(); end
        end else if (first_from(j, 1'b0) >= 0) begin
          m_double = 1; seq.delete();
        end
`else
        m_short = 1; seq.delete();
`endif
      end
    end
    m_held = (seq.size() > LT) && (first_from(0, 1'b0) < 0);
    m_busy = (seq.size() != 0);
  endtask

  function automatic logic [4:0] dut_out();
    return {bus.press_short, bus.press_long, bus.press_double, bus.held, bus.busy};
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // One clock: drive level, let the edge sample it, compare against the model
  task automatic step(bit v, string tag);
    bus.in_level = v;
    @(posedge clk);
    model_step(v);
    #1;
    chk(tag, dut_out(), {m_short, m_long, m_double, m_held, m_busy});
    chk({tag, "_onehot"}, 5'($countones({bus.press_short, bus.press_long, bus.press_double}) <= 1), 5'd1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, "idle");
  endtask

  task automatic press(int n, string tag);
    for (int i = 0; i < n; i++) step(1'b1, tag);
  endtask

  // Release then count edges until press_short; -1 if it never comes
  task automatic release_until_short(output int d);
    d = -1;
    for (int i = 0; i < 3 * GT + 4; i++) begin
      step(1'b0, "rel");
      if (bus.press_short) begin d = i; break; end
    end
  endtask

  int d;
  int exp_d;
  bit lvl;
  int len;

  initial begin
    tbl[0]  = '{1'b1, 5'b00001}; tbl[1]  = '{1'b1, 5'b00001};
    tbl[2]  = '{1'b1, 5'b00001}; tbl[3]  = '{1'b1, 5'b00001};
    tbl[4]  = '{1'b1, 5'b00001}; tbl[5]  = '{1'b1, 5'b00001};
    tbl[6]  = '{1'b1, 5'b00001}; tbl[7]  = '{1'b1, 5'b00001};
    tbl[8]  = '{1'b1, 5'b01011}; tbl[9]  = '{1'b1, 5'b00011};
    tbl[10] = '{1'b1, 5'b00011}; tbl[11] = '{1'b1, 5'b00011};
    tbl[12] = '{1'b0, 5'b00000}; tbl[13] = '{1'b0, 5'b00000};
`ifdef BTN_DOUBLE_EN
    exp_d = GT;
`else
    exp_d = 0;
`endif

    // Reset state
    rst = 1'b0;
    bus.in_level = 1'b0;
    #1;
    chk("reset_outputs", dut_out(), 5'b00000);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Reset mid-PRESSED: outputs clear immediately, no pulse afterwards
    press(3, "pre_rst");
    #2 rst = 1'b0;
    #1 chk("rst_mid_async", dut_out(), 5'b00000);
    seq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(GT + 4);

    // Long press from the vector table
    for (int i = 0; i < 14; i++) begin
      bus.in_level = tbl[i].in;
      @(posedge clk);
      model_step(tbl[i].in);
      #1;
      chk($sformatf("tbl_long_%0d", i), dut_out(), tbl[i].exp);
    end
    idle(2);

    // Short press latency
    press(3, "short");
    release_until_short(d);
    chk("short_latency", 5'(d), 5'(exp_d));
    idle(GT + 2);

    // Boundary: release on the long-threshold cycle, then one cycle later
    press(LT, "bnd_s");
    step(1'b0, "bnd_rel");
    chk("bnd_no_long", 5'(bus.press_long), 5'd0);
    idle(GT + 2);
    press(LT + 1, "bnd_l");
    chk("bnd_long", 5'(bus.press_long), 5'd1);
    idle(3);

`ifdef BTN_DOUBLE_EN
    // Double click: 2 high, 2 low, 2 high, release
    press(2, "dbl1"); idle(2); press(2, "dbl2");
    step(1'b0, "dbl_rel");
    chk("dbl_pulse", {bus.press_short, bus.press_double}, 5'b00001);
    idle(GT + 2);
    // Re-press exactly on the timeout cycle still makes a double
    press(2, "to1"); idle(GT); press(1, "to2");
    step(1'b0, "to_rel");
    chk("timeout_repress_double", 5'(bus.press_double), 5'd1);
    idle(GT + 2);
    // Gap past the window: short, then second press classified alone
    press(2, "sep1");
    release_until_short(d);
    chk("sep_short", 5'(d), 5'(GT));
    step(1'b0, "sep_gap");
    press(2, "sep2");
    release_until_short(d);
    chk("sep_second_short", 5'(d), 5'(GT));
    idle(GT + 2);
`endif

    // Back-to-back: new press in the press_short pulse cycle
    press(3, "b2b1");
    release_until_short(d);
    chk("b2b_first", 5'(d), 5'(exp_d));
    step(1'b1, "b2b_press");
    chk("b2b_busy", 5'(bus.busy), 5'd1);
    press(LT, "b2b_long");
    idle(GT + 2);

    // Random run lengths around the thresholds, with occasional resets
    lvl = 1'b0;
    for (int b = 0; b < 400; b++) begin
      lvl = ~lvl;
      len = $urandom_range(1, LT + 4);
      for (int i = 0; i < len; i++) step(lvl, "rand");
      if ($urandom_range(0, 40) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rand_rst", dut_out(), 5'b00000);
        seq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
    idle(GT + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
